// File: rtl/screen_ctrl_pkg.sv
// Shared game package: screen codes used by the screen controller and the screen drawer,
// plus sizing helpers for the hold counter.
package screen_ctrl_pkg;

   localparam int SCREEN_W = 2;

   typedef enum logic [SCREEN_W-1:0] {
      S_START = 2'd0,
      S_PLAY  = 2'd1,
      S_LOSE  = 2'd2,
      S_WIN   = 2'd3
   } screen_t;

   // Counter width able to hold the larger hold value; never narrower than one bit.
   function automatic int hold_cnt_w(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/screen_ctrl_edge_latch.sv
// Event detector with a sticky pending flag. hit reflects the stored flag ORed with the
// current event, so an event coincident with a frame boundary is honoured that cycle.
module edge_latch #(
   parameter bit EDGE_DET = 1'b1,
   parameter bit PREV_RST = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic sig,
   input  logic clr,
   output logic hit
);

   logic prev_q;
   logic pend_q;
   logic pend_d;
   logic evt;

   // Previous value resets high so a level held through reset is not seen as an edge.
   assign evt    = EDGE_DET ? (sig & ~prev_q) : sig;
   assign hit    = pend_q | evt;
   assign pend_d = clr ? 1'b0 : hit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_q <= PREV_RST;
         pend_q <= 1'b0;
      end else begin
         prev_q <= sig;
         pend_q <= pend_d;
      end
   end

endmodule

// File: rtl/screen_ctrl.sv
// Game screen sequencer: START -> PLAY -> LOSE/WIN -> START, with every change aligned
// to a frame boundary and a minimum hold time on the outcome screens.
module screen_ctrl
   import screen_ctrl_pkg::*;
#(
   parameter int LOSE_HOLD_FRAMES = 120,
   parameter int WIN_HOLD_FRAMES  = 120
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                frame_start,
   input  logic                key_enter,
   input  logic                key_space,
   input  logic                lose,
   input  logic                win,
   output logic [SCREEN_W-1:0] screen_sel,
   output logic                game_run,
   output logic                start_game,
   output logic                game_rst
);

   localparam int CNT_W = hold_cnt_w(LOSE_HOLD_FRAMES, WIN_HOLD_FRAMES);
   localparam logic [CNT_W-1:0] LOSE_HOLD = CNT_W'(LOSE_HOLD_FRAMES);
   localparam logic [CNT_W-1:0] WIN_HOLD  = CNT_W'(WIN_HOLD_FRAMES);

   screen_t          state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] hold;
   logic             start_q, start_d;
   logic             grst_q, grst_d;
   logic             run_q, run_d;
   logic             go_hit, lose_hit, win_hit;
   logic             go_clr, trans, hold_done;

   edge_latch #(.EDGE_DET(1'b1), .PREV_RST(1'b1)) u_go (
      .clk (clk),
      .rst (rst),
      .sig (key_enter | key_space),
      .clr (go_clr),
      .hit (go_hit)
   );

   edge_latch #(.EDGE_DET(1'b0), .PREV_RST(1'b0)) u_lose (
      .clk (clk),
      .rst (rst),
      .sig (lose),
      .clr (trans),
      .hit (lose_hit)
   );

   edge_latch #(.EDGE_DET(1'b0), .PREV_RST(1'b0)) u_win (
      .clk (clk),
      .rst (rst),
      .sig (win),
      .clr (trans),
      .hit (win_hit)
   );

   assign hold      = (state_q == S_WIN) ? WIN_HOLD : LOSE_HOLD;
   assign hold_done = (cnt_q >= hold);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      start_d = 1'b0;
      grst_d  = 1'b0;
      trans   = 1'b0;
      go_clr  = 1'b0;
      case (state_q)
         S_START: begin
            if (frame_start && go_hit) begin
               state_d = S_PLAY;
               start_d = 1'b1;
               grst_d  = 1'b1;
               trans   = 1'b1;
            end
         end
         S_PLAY: begin
            go_clr = 1'b1;
            if (frame_start && lose_hit) begin
               state_d = S_LOSE;
               trans   = 1'b1;
            end else if (frame_start && win_hit) begin
               state_d = S_WIN;
               trans   = 1'b1;
            end
         end
         S_LOSE, S_WIN: begin
            // Keys pressed during the hold window are dropped, not deferred.
            if (!hold_done) begin
               go_clr = 1'b1;
            end
            if (frame_start) begin
               if (hold_done && go_hit) begin
                  state_d = S_START;
                  grst_d  = 1'b1;
                  trans   = 1'b1;
               end else if (!hold_done) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = S_START;
            trans   = 1'b1;
         end
      endcase
      if (trans) begin
         go_clr = 1'b1;
         cnt_d  = '0;
      end
      run_d = (state_d == S_PLAY);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_START;
         cnt_q   <= '0;
         start_q <= 1'b0;
         grst_q  <= 1'b0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         start_q <= start_d;
         grst_q  <= grst_d;
         run_q   <= run_d;
      end
   end

   assign screen_sel = state_q;
   assign game_run   = run_q;
   assign start_game = start_q;
   assign game_rst   = grst_q;

endmodule

// File: tb/tb_screen_ctrl.sv
// Directed bench for screen_ctrl: a frame-level reference model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_screen_ctrl;

   localparam int LH = 4;
   localparam int WH = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       frame_start = 1'b0;
   logic       key_enter = 1'b0;
   logic       key_space = 1'b0;
   logic       lose = 1'b0;
   logic       win = 1'b0;
   logic [1:0] screen_sel;
   logic       game_run;
   logic       start_game;
   logic       game_rst;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   screen_ctrl #(.LOSE_HOLD_FRAMES(LH), .WIN_HOLD_FRAMES(WH)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .key_enter   (key_enter),
      .key_space   (key_space),
      .lose        (lose),
      .win         (win),
      .screen_sel  (screen_sel),
      .game_run    (game_run),
      .start_game  (start_game),
      .game_rst    (game_rst)
   );

   always #5 clk = ~clk;

   // Reference model: screen number, frames seen since entering an outcome screen,
   // and whether a keypress / outcome is waiting for the next frame boundary.
   int m_scr    = 0;
   int m_frames = 0;
   bit m_prev   = 1'b1;
   bit m_go     = 1'b0;
   bit m_lw     = 1'b0;
   bit m_ww     = 1'b0;
   bit m_start  = 1'b0;
   bit m_grst   = 1'b0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_scr <= 0; m_frames <= 0; m_prev <= 1'b1;
         m_go <= 1'b0; m_lw <= 1'b0; m_ww <= 1'b0;
         m_start <= 1'b0; m_grst <= 1'b0;
      end else begin
         automatic bit k   = key_enter | key_space;
         automatic bit e   = k & ~m_prev;
         automatic int scr = m_scr;
         automatic int fr  = m_frames;
         automatic bit go  = m_go;
         automatic bit lw  = m_lw;
         automatic bit ww  = m_ww;
         automatic bit st  = 1'b0;
         automatic bit gr  = 1'b0;
         automatic int hold;
         case (scr)
            0: begin
               go = go | e;
               if (frame_start && go) begin scr = 1; st = 1'b1; gr = 1'b1; end
            end
            1: begin
               go = 1'b0;
               lw = lw | lose;
               ww = ww | win;
               if (frame_start) begin
                  if (lw) scr = 2;
                  else if (ww) scr = 3;
               end
            end
            default: begin
               hold = (scr == 2) ? LH : WH;
               if (fr >= hold) go = go | e;
               else go = 1'b0;
               if (frame_start) begin
                  if (fr >= hold && go) begin scr = 0; gr = 1'b1; end
                  else fr = fr + 1;
               end
            end
         endcase
         if (scr != m_scr) begin
            go = 1'b0; lw = 1'b0; ww = 1'b0; fr = 0;
            $display("[%0t] screen %0d -> %0d", $time, m_scr, scr);
         end
         m_prev <= k; m_scr <= scr; m_frames <= fr;
         m_go <= go; m_lw <= lw; m_ww <= ww;
         m_start <= st; m_grst <= gr;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         n_vec = n_vec + 1;
         if (screen_sel != 2'(m_scr) || game_run != (m_scr == 1) ||
             start_game != m_start || game_rst != m_grst) begin
            n_err = n_err + 1;
            $display("FAIL model_cmp t=%0t got sel=%0d run=%0b start=%0b grst=%0b, want sel=%0d run=%0b start=%0b grst=%0b",
                     $time, screen_sel, game_run, start_game, game_rst,
                     m_scr, (m_scr == 1), m_start, m_grst);
         end
      end
   end

   task automatic chk(input string name, input int got, input int want);
      n_vec = n_vec + 1;
      if (got != want) begin
         n_err = n_err + 1;
         $display("FAIL %s t=%0t got %0d want %0d", name, $time, got, want);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One frame boundary; returns 1 ns after the cycle in which its effect is visible.
   task automatic frame_edge();
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      #1;
   endtask

   task automatic tap_space();
      key_space = 1'b1;
      idle(1);
      key_space = 1'b0;
      idle(1);
   endtask

   initial begin
      key_enter = 1'b1;
      idle(3);
      chk_en = 1'b1;
      #1;
      chk("rst_sel", int'(screen_sel), 0);
      chk("rst_run", int'(game_run), 0);
      chk("rst_grst", int'(game_rst), 0);

      // Enter held across reset release must not start the game.
      rst = 1'b1;
      for (int f = 0; f < 3; f++) begin
         idle(3);
         frame_edge();
         chk("held_key_no_go", int'(screen_sel), 0);
      end

      key_enter = 1'b0;
      idle(2);
      key_enter = 1'b1;
      idle(2);
      key_enter = 1'b0;
      frame_edge();
      chk("start_sel", int'(screen_sel), 1);
      chk("start_pulse", int'(start_game), 1);
      chk("start_grst", int'(game_rst), 1);
      chk("start_run", int'(game_run), 1);
      idle(1);
      chk("start_pulse_end", int'(start_game), 0);
      chk("grst_pulse_end", int'(game_rst), 0);

      tap_space();
      frame_edge();
      chk("play_ignores_go", int'(screen_sel), 1);

      lose = 1'b1; win = 1'b1;
      idle(1);
      lose = 1'b0; win = 1'b0;
      idle(2);
      frame_edge();
      chk("lose_priority", int'(screen_sel), 2);
      chk("lose_no_grst", int'(game_rst), 0);
      chk("lose_run", int'(game_run), 0);

      // Lose hold of 4 frames: early press dropped, later press honoured.
      frame_edge();
      frame_edge();
      tap_space();
      frame_edge();
      chk("lose_hold_f3", int'(screen_sel), 2);
      frame_edge();
      chk("lose_hold_f4", int'(screen_sel), 2);
      idle(2);
      frame_edge();
      chk("lose_early_key_dropped", int'(screen_sel), 2);
      tap_space();
      frame_edge();
      chk("lose_return_sel", int'(screen_sel), 0);
      chk("lose_return_grst", int'(game_rst), 1);
      chk("lose_return_nostart", int'(start_game), 0);

      // Go edge in the same cycle as frame_start.
      idle(3);
      @(negedge clk);
      frame_start = 1'b1;
      key_enter = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      #1;
      chk("coincident_go_sel", int'(screen_sel), 1);
      chk("coincident_go_start", int'(start_game), 1);
      key_enter = 1'b0;
      idle(2);

      win = 1'b1;
      idle(1);
      win = 1'b0;
      frame_edge();
      chk("win_sel", int'(screen_sel), 3);
      tap_space();
      frame_edge();
      chk("win_hold_f1", int'(screen_sel), 3);
      frame_edge();
      chk("win_hold_f2", int'(screen_sel), 3);
      tap_space();
      frame_edge();
      chk("win_return_sel", int'(screen_sel), 0);
      chk("win_return_grst", int'(game_rst), 1);

      // Reset in the middle of a win hold.
      key_space = 1'b1;
      idle(1);
      key_space = 1'b0;
      frame_edge();
      chk("replay_sel", int'(screen_sel), 1);
      win = 1'b1;
      idle(1);
      win = 1'b0;
      frame_edge();
      chk("win2_sel", int'(screen_sel), 3);
      frame_edge();
      #2;
      rst = 1'b0;
      #1;
      chk("rst_mid_sel", int'(screen_sel), 0);
      chk("rst_mid_run", int'(game_run), 0);
      chk("rst_mid_start", int'(start_game), 0);
      chk("rst_mid_grst", int'(game_rst), 0);
      idle(2);
      rst = 1'b1;
      idle(3);
      frame_edge();
      chk("post_rst_idle", int'(screen_sel), 0);
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/screen_ctrl.md
SCREEN_CTRL -- requirements
Module: screen_ctrl

Interface
REQ-001 The module SHALL take parameter LOSE_HOLD_FRAMES, default 120, the number of frames the lose screen is held before keys are accepted.
REQ-002 The module SHALL take parameter WIN_HOLD_FRAMES, default 120, the number of frames the win screen is held before keys are accepted.
REQ-003 The module SHALL have port clk, input, 1 bit, the single system clock; all logic is in this domain.
REQ-004 The module SHALL have port rst, input, 1 bit, reset, asynchronous, active-low.
REQ-005 The module SHALL have port frame_start, input, 1 bit, a one-cycle pulse at hcount=0, vcount=0.
REQ-006 The module SHALL have ports key_enter and key_space, inputs, 1 bit each, level-sensitive key states from the keyboard decoder.
REQ-007 The module SHALL have ports lose and win, inputs, 1 bit each, level or pulse game-outcome flags from game logic.
REQ-008 The module SHALL have port screen_sel, output, 2 bits, the active screen: 0=START, 1=PLAY, 2=LOSE, 3=WIN.
REQ-009 The module SHALL have port game_run, output, 1 bit, high only while in PLAY.
REQ-010 The module SHALL have port start_game, output, 1 bit, a one-cycle pulse on the START->PLAY transition.
REQ-011 The module SHALL have port game_rst, output, 1 bit, a one-cycle pulse on every transition into START or PLAY.

Function
REQ-012 go SHALL be the rising edge of (key_enter | key_space), detected with a registered previous value.
REQ-013 go, lose and win SHALL set sticky pending flags; every state transition SHALL take effect only on a cycle with frame_start=1, so screens change only at frame boundaries.
REQ-014 FSM states SHALL be S_START, S_PLAY, S_LOSE and S_WIN; screen_sel SHALL equal the state encoding and be registered.
REQ-015 In S_START, on frame_start with go pending: -> S_PLAY, with start_game and game_rst high for exactly that cycle.
REQ-016 In S_PLAY, on frame_start with lose pending: -> S_LOSE; otherwise with win pending: -> S_WIN; lose SHALL have priority when both are pending.
REQ-017 In S_PLAY, pending go SHALL be ignored and cleared.
REQ-018 On entry to S_LOSE or S_WIN, the hold counter SHALL clear; it SHALL increment on each frame_start and saturate at the state's HOLD value.
REQ-019 While the hold counter is below HOLD, go edges SHALL be discarded and the go pending flag held clear.
REQ-020 In S_LOSE or S_WIN, on frame_start with counter = HOLD and go pending: -> S_START, with game_rst pulsed for that cycle.
REQ-021 All pending flags SHALL clear on every state transition.
REQ-022 The counter width SHALL be $clog2(max(LOSE_HOLD_FRAMES, WIN_HOLD_FRAMES)+1).
REQ-023 A HOLD value of 0 SHALL allow an immediate return on the first frame_start with go pending.
REQ-024 A go edge and frame_start in the same cycle SHALL be honoured in that cycle (the pending flag is ORed with the current edge).
REQ-025 Output latency SHALL be 1 clk from the qualifying frame_start to the updated screen_sel and the pulses.

Reset
REQ-026 While rst=0: state S_START, screen_sel=0, game_run=0, start_game=0, game_rst=0, counter=0, all pending flags=0.
REQ-027 The key-previous register SHALL reset to 1, so a key held through reset does not generate go.
REQ-028 Reset asserted mid-operation SHALL abort any state immediately, with no pulse emitted.

Structure
REQ-029 The state enum (screen_t) and the screen_sel encodings SHALL live in the shared game package, so the screen drawer uses the same codes.
REQ-030 Edge detection plus the sticky flag SHALL be one sub-module, edge_latch, instantiated once per event (go, lose, win).

Verification
REQ-031 Reset release, then Enter pressed mid-frame: start_game and game_rst pulse 1 cycle after the next frame_start; screen_sel=1; game_run=1.
REQ-032 Key held across reset release: no transition for 3 frames; release and re-press: transition at the next frame.
REQ-033 In PLAY, lose and win asserted in the same frame: screen_sel=2 after frame_start.
REQ-034 LOSE_HOLD_FRAMES=4, Space pressed at frame 2 after entry: ignored; pressed at frame 5: screen_sel=0 after the next frame_start, with game_rst pulsed.
REQ-035 Go edge coincident with frame_start in S_START: screen_sel=1 on the next clk.
REQ-036 rst asserted in S_WIN mid-hold: immediately screen_sel=0 and counter=0; no start_game pulse.
